d8_alu_seq: RTL and testbench
=============================

D8_ALU_SEQ -- requirements
Module: d8_alu_seq

Interface
REQ-001 Parameter: none; all widths fixed at 8 bits.
REQ-002 sys_clk  in  1  single clock, all state updates on rising edge.
REQ-003 sys_rst  in  1  reset, synchronous and active-high.
REQ-004 start  in  1  one-cycle request; samples op, a_in, b_in when accepted.
REQ-005 op  in  8  opcode: 8'h01 ADD, 8'h02 SUB, 8'h03 MUL, 8'h04 DIV, other = pass.
REQ-006 a_in  in  8  operand A (dividend, minuend, augend).
REQ-007 b_in  in  8  operand B (divisor, subtrahend, addend).
REQ-008 busy  out  1  high while an operation is in progress.
REQ-009 done  out  1  one-cycle pulse when s/s_hi/flags are valid.
REQ-010 s  out  8  result low byte (sum, difference, product low, quotient), consumed by the ALU output mux.
REQ-011 s_hi  out  8  product high byte (MUL) or remainder (DIV); 8'h00 otherwise.
REQ-012 flag_z  out  1  s == 0.
REQ-013 flag_c  out  1  carry (ADD), borrow (SUB), s_hi != 0 (MUL), 0 (DIV).
REQ-014 flag_e  out  1  divide-by-zero error; 0 for all other ops.

Function
REQ-015 The block SHALL implement states IDLE, CALC, DONE.
REQ-016 In IDLE, start=1 SHALL be accepted, with operands and op latched in the same edge.
REQ-017 Transition: ADD, SUB, and unsupported op SHALL go from IDLE to DONE, with done high exactly 1 cycle after the start cycle.
REQ-018 Transition: MUL and DIV SHALL go from IDLE to CALC for exactly 8 cycles, then to DONE, with done high 9 cycles after the start cycle.
REQ-019 DONE SHALL last one cycle, pulse done, and return to IDLE.
REQ-020 busy SHALL be high in CALC and DONE; a start in the DONE cycle SHALL be ignored.
REQ-021 start while busy SHALL be ignored, with no effect on the in-flight operation.
REQ-022 ADD SHALL compute the 9-bit sum {flag_c,s} = a+b.
REQ-023 SUB SHALL compute s = a-b mod 256 and set flag_c = (a < b).
REQ-024 MUL SHALL be an unsigned shift-add, one bit per CALC cycle, giving {s_hi,s} = a*b (16 bits).
REQ-025 DIV SHALL be an unsigned restoring division, one bit per CALC cycle, giving s = a/b and s_hi = a%b.
REQ-026 DIV with b=0 SHALL run the full 9-cycle latency and return s=8'hFF, s_hi=a, flag_e=1.
REQ-027 An unsupported op SHALL return s=b_in, s_hi=0, and all flags 0.
REQ-028 s, s_hi and the flags SHALL hold their values from the done cycle until the next accepted start completes.
REQ-029 Intermediate iteration values SHALL NOT appear on s or s_hi before done.

Reset
REQ-030 sys_rst SHALL force IDLE, with busy=0, done=0, s=0, s_hi=0, and all flags 0, on the next edge.
REQ-031 sys_rst during CALC or DONE SHALL abort the operation with no done pulse; start in the same cycle as sys_rst SHALL be ignored.

Structure
REQ-032 Opcode constants (ALU_ADD..ALU_DIV) SHALL live in the shared d8 defines include, also used by the output mux and the decoder.
REQ-033 The iterative datapath SHALL be one sub-module, d8_alu_muldiv (shift registers, 3-bit iteration counter, mode input); the FSM and ADD/SUB SHALL stay in d8_alu_seq.

Verification
REQ-034 ADD a=8'hFF b=8'h01 -> done at +1, s=8'h00, flag_c=1, flag_z=1, s_hi=0.
REQ-035 SUB a=8'h10 b=8'h20 -> done at +1, s=8'hF0, flag_c=1, flag_z=0.
REQ-036 MUL a=8'h10 b=8'h11 -> busy for 9 cycles, done at +9, s=8'h10, s_hi=8'h01, flag_c=1; start pulsed at +4 ignored.
REQ-037 DIV a=8'hC8 b=8'h07 -> done at +9, s=8'h1C, s_hi=8'h04; then DIV b=0 -> s=8'hFF, s_hi=8'hC8, flag_e=1.
REQ-038 MUL started, sys_rst at +5 -> no done pulse, all outputs 0 at +6; a new ADD 8'h02+8'h03 then gives s=8'h05 at +1.
REQ-039 op=8'h07 a=8'h55 b=8'hAA -> done at +1, s=8'hAA, s_hi=0, all flags 0.

Source files
------------

// File: rtl/d8_alu_seq_pkg.sv
// Shared definitions for the d8 sequential ALU.
// Holds the opcode constants, the control FSM states and the iterative-unit mode.
package d8_alu_seq_pkg;

    localparam logic [7:0] ALU_ADD = 8'h01;
    localparam logic [7:0] ALU_SUB = 8'h02;
    localparam logic [7:0] ALU_MUL = 8'h03;
    localparam logic [7:0] ALU_DIV = 8'h04;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } alu_state_e;

    typedef enum logic {
        MD_MUL = 1'b0,
        MD_DIV = 1'b1
    } md_mode_e;

endpackage

// File: rtl/d8_alu_muldiv.sv
// Iterative 8-bit unsigned multiplier / restoring divider, one bit per step.
// Exposes the post-step values so the caller can capture the final result on the last step.
module d8_alu_muldiv
    import d8_alu_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic        i_step,
    input  md_mode_e    i_mode,
    input  logic [7:0]  i_a,
    input  logic [7:0]  i_b,
    output logic [7:0]  o_lo_nxt,
    output logic [7:0]  o_hi_nxt,
    output logic        o_last
);

    logic [7:0] r_lo;
    logic [7:0] r_hi;
    logic [7:0] r_opd;
    logic [2:0] r_cnt;
    md_mode_e   r_mode;

    logic [8:0] w_sum;
    logic [8:0] w_trial;
    logic [8:0] w_diff;
    logic       w_ge;

    // MUL: r_lo holds the multiplier, shifted right as product bits arrive from r_hi.
    // DIV: r_lo holds the dividend, shifted left while quotient bits fill in from the right.
    always_comb begin
        w_sum    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opd} : 9'd0);
        w_trial  = {r_hi, r_lo[7]};
        w_ge     = (w_trial >= {1'b0, r_opd});
        w_diff   = w_trial - {1'b0, r_opd};
        o_hi_nxt = w_sum[8:1];
        o_lo_nxt = {w_sum[0], r_lo[7:1]};
        if (r_mode == MD_DIV) begin
            o_hi_nxt = w_ge ? w_diff[7:0] : w_trial[7:0];
            o_lo_nxt = {r_lo[6:0], w_ge};
        end
    end

    assign o_last = (r_cnt == 3'd7);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= 3'd0;
            r_mode <= MD_MUL;
        end else if (i_load) begin
            r_cnt  <= 3'd0;
            r_mode <= i_mode;
        end else if (i_step) begin
            r_cnt  <= r_cnt + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_load) begin
            r_lo  <= (i_mode == MD_MUL) ? i_b : i_a;
            r_hi  <= 8'h00;
            r_opd <= (i_mode == MD_MUL) ? i_a : i_b;
        end else if (i_step) begin
            r_lo  <= o_lo_nxt;
            r_hi  <= o_hi_nxt;
        end
    end

endmodule

// File: rtl/d8_alu_seq.sv
// d8 sequential ALU: single-cycle ADD/SUB/pass, 8-step MUL/DIV via d8_alu_muldiv.
// Results are registered and only change on the edge that completes an operation.
module d8_alu_seq
    import d8_alu_seq_pkg::*;
(
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        start,
    input  logic [7:0]  op,
    input  logic [7:0]  a_in,
    input  logic [7:0]  b_in,
    output logic        busy,
    output logic        done,
    output logic [7:0]  s,
    output logic [7:0]  s_hi,
    output logic        flag_z,
    output logic        flag_c,
    output logic        flag_e
);

    alu_state_e r_state;
    alu_state_e w_state_nxt;

    logic [7:0] r_op;
    logic       r_bz;
    logic [7:0] r_s;
    logic [7:0] r_s_hi;
    logic       r_z;
    logic       r_c;
    logic       r_e;

    logic       w_accept;
    logic       w_iter;
    logic       w_last;
    logic [8:0] w_add;
    logic [7:0] w_sub;
    logic [7:0] w_lo_nxt;
    logic [7:0] w_hi_nxt;

    assign w_accept = (r_state == ST_IDLE) && start;
    assign w_iter   = (op == ALU_MUL) || (op == ALU_DIV);
    assign w_add    = {1'b0, a_in} + {1'b0, b_in};
    assign w_sub    = a_in - b_in;

    d8_alu_muldiv u_muldiv (
        .clk      (sys_clk),
        .rst      (sys_rst),
        .i_load   (w_accept && w_iter),
        .i_step   (r_state == ST_CALC),
        .i_mode   ((op == ALU_DIV) ? MD_DIV : MD_MUL),
        .i_a      (a_in),
        .i_b      (b_in),
        .o_lo_nxt (w_lo_nxt),
        .o_hi_nxt (w_hi_nxt),
        .o_last   (w_last)
    );

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (start) w_state_nxt = w_iter ? ST_CALC : ST_DONE;
            ST_CALC: if (w_last) w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Single-cycle ops land at the accept edge; MUL/DIV land on the edge of the last step.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_op   <= 8'h00;
            r_bz   <= 1'b0;
            r_s    <= 8'h00;
            r_s_hi <= 8'h00;
            r_z    <= 1'b0;
            r_c    <= 1'b0;
            r_e    <= 1'b0;
        end else if (w_accept) begin
            r_op <= op;
            r_bz <= (b_in == 8'h00);
            case (op)
                ALU_ADD: begin
                    r_s    <= w_add[7:0];
                    r_s_hi <= 8'h00;
                    r_z    <= (w_add[7:0] == 8'h00);
                    r_c    <= w_add[8];
                    r_e    <= 1'b0;
                end
                ALU_SUB: begin
                    r_s    <= w_sub;
                    r_s_hi <= 8'h00;
                    r_z    <= (w_sub == 8'h00);
                    r_c    <= (a_in < b_in);
                    r_e    <= 1'b0;
                end
                ALU_MUL, ALU_DIV: begin
                end
                default: begin
                    r_s    <= b_in;
                    r_s_hi <= 8'h00;
                    r_z    <= 1'b0;
                    r_c    <= 1'b0;
                    r_e    <= 1'b0;
                end
            endcase
        end else if ((r_state == ST_CALC) && w_last) begin
            r_s    <= w_lo_nxt;
            r_s_hi <= w_hi_nxt;
            r_z    <= (w_lo_nxt == 8'h00);
            r_c    <= (r_op == ALU_MUL) && (w_hi_nxt != 8'h00);
            r_e    <= (r_op == ALU_DIV) && r_bz;
        end
    end

    assign busy   = (r_state != ST_IDLE);
    assign done   = (r_state == ST_DONE);
    assign s      = r_s;
    assign s_hi   = r_s_hi;
    assign flag_z = r_z;
    assign flag_c = r_c;
    assign flag_e = r_e;

endmodule

// File: tb/tb_d8_alu_seq.sv
// Self-checking bench for d8_alu_seq: directed vector table, reset-abort sequence,
// and random operations checked against an arithmetic reference model.
module tb_d8_alu_seq;

    logic       clk = 1'b0;
    logic       sys_rst;
    logic       start;
    logic [7:0] op;
    logic [7:0] a_in;
    logic [7:0] b_in;
    logic       busy;
    logic       done;
    logic [7:0] s;
    logic [7:0] s_hi;
    logic       flag_z;
    logic       flag_c;
    logic       flag_e;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [7:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] s;
        logic [7:0] hi;
        logic       z;
        logic       c;
        logic       e;
        int         lat;
        int         inj;
    } vec_t;

    vec_t tbl [10];

    d8_alu_seq dut (
        .sys_clk (clk),
        .sys_rst (sys_rst),
        .start   (start),
        .op      (op),
        .a_in    (a_in),
        .b_in    (b_in),
        .busy    (busy),
        .done    (done),
        .s       (s),
        .s_hi    (s_hi),
        .flag_z  (flag_z),
        .flag_c  (flag_c),
        .flag_e  (flag_e)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: results from plain arithmetic on the operands.
    function automatic vec_t model(input logic [7:0] o, input logic [7:0] a, input logic [7:0] b);
        vec_t v;
        logic [8:0]  t;
        logic [15:0] p;
        v.op = o; v.a = a; v.b = b;
        v.hi = 8'h00; v.z = 1'b0; v.c = 1'b0; v.e = 1'b0; v.lat = 1; v.inj = -1;
        case (o)
            8'h01: begin t = a + b; v.s = t[7:0]; v.c = t[8]; v.z = (v.s == 0); end
            8'h02: begin v.s = a - b; v.c = (a < b); v.z = (v.s == 0); end
            8'h03: begin
                p = a * b; v.s = p[7:0]; v.hi = p[15:8];
                v.c = (v.hi != 0); v.z = (v.s == 0); v.lat = 9;
            end
            8'h04: begin
                v.lat = 9;
                if (b == 0) begin v.s = 8'hFF; v.hi = a; v.e = 1'b1; end
                else begin v.s = a / b; v.hi = a % b; end
                v.z = (v.s == 0);
            end
            default: v.s = b;
        endcase
        return v;
    endfunction

    task automatic do_op(input vec_t v, input string nm);
        logic [7:0] prev_s;
        logic [7:0] prev_hi;
        int lat;
        @(negedge clk);
        prev_s = s; prev_hi = s_hi;
        start = 1'b1; op = v.op; a_in = v.a; b_in = v.b;
        @(negedge clk);
        start = 1'b0;
        for (lat = 1; lat <= 20; lat++) begin
            if (done) break;
            chk({nm, "_busy"}, 16'(busy), 16'd1);
            chk({nm, "_s_hold"}, {prev_hi, prev_s}, {s_hi, s});
            if (lat == v.inj) begin
                start = 1'b1; op = 8'h01; a_in = 8'h77; b_in = 8'h11;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk({nm, "_latency"}, 16'(lat), 16'(v.lat));
        if (lat > 20) return;
        chk({nm, "_busy_done"}, 16'(busy), 16'd1);
        chk({nm, "_s"}, {s_hi, s}, {v.hi, v.s});
        chk({nm, "_flags"}, {13'd0, flag_z, flag_c, flag_e}, {13'd0, v.z, v.c, v.e});
        if (lat == v.inj) begin
            start = 1'b1; op = 8'h01; a_in = 8'h77; b_in = 8'h11;
        end
        @(negedge clk);
        start = 1'b0;
        chk({nm, "_idle"}, {14'd0, busy, done}, 16'd0);
        chk({nm, "_hold"}, {s_hi, s}, {v.hi, v.s});
    endtask

    initial begin
        vec_t v;
        tbl[0] = '{8'h01, 8'hFF, 8'h01, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1, -1};
        tbl[1] = '{8'h02, 8'h10, 8'h20, 8'hF0, 8'h00, 1'b0, 1'b1, 1'b0, 1, -1};
        tbl[2] = '{8'h03, 8'h10, 8'h11, 8'h10, 8'h01, 1'b0, 1'b1, 1'b0, 9, 4};
        tbl[3] = '{8'h04, 8'hC8, 8'h07, 8'h1C, 8'h04, 1'b0, 1'b0, 1'b0, 9, -1};
        tbl[4] = '{8'h04, 8'hC8, 8'h00, 8'hFF, 8'hC8, 1'b0, 1'b0, 1'b1, 9, 9};
        tbl[5] = '{8'h07, 8'h55, 8'hAA, 8'hAA, 8'h00, 1'b0, 1'b0, 1'b0, 1, -1};
        tbl[6] = '{8'h03, 8'h00, 8'h5A, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 9, -1};
        tbl[7] = '{8'h02, 8'h30, 8'h30, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1, 1};
        tbl[8] = '{8'h04, 8'hFF, 8'hFF, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 9, 3};
        tbl[9] = '{8'h03, 8'hFF, 8'hFF, 8'h01, 8'hFE, 1'b0, 1'b1, 1'b0, 9, -1};

        sys_rst = 1'b1; start = 1'b0; op = 8'h00; a_in = 8'h00; b_in = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset_ctl", {14'd0, busy, done}, 16'd0);
        chk("reset_data", {s_hi, s}, 16'd0);
        chk("reset_flags", {13'd0, flag_z, flag_c, flag_e}, 16'd0);
        sys_rst = 1'b0;

        for (int i = 0; i < 10; i++) do_op(tbl[i], $sformatf("vec%0d", i));

        // MUL aborted by reset at +5 with a simultaneous start that must be ignored.
        @(negedge clk);
        start = 1'b1; op = 8'h03; a_in = 8'h10; b_in = 8'h11;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            start = 1'b0;
            chk("abort_no_done", 16'(done), 16'd0);
            if (k == 5) begin
                sys_rst = 1'b1; start = 1'b1; op = 8'h01; a_in = 8'h01; b_in = 8'h01;
            end
        end
        @(negedge clk);
        sys_rst = 1'b0; start = 1'b0;
        chk("abort_ctl", {14'd0, busy, done}, 16'd0);
        chk("abort_data", {s_hi, s}, 16'd0);
        chk("abort_flags", {13'd0, flag_z, flag_c, flag_e}, 16'd0);
        do_op(model(8'h01, 8'h02, 8'h03), "post_abort_add");

        for (int i = 0; i < 200; i++) begin
            logic [7:0] ro;
            logic [7:0] rb;
            case ($urandom_range(0, 5))
                0: ro = 8'h01;
                1: ro = 8'h02;
                2: ro = 8'h03;
                3: ro = 8'h04;
                4: ro = 8'h04;
                default: ro = 8'($urandom);
            endcase
            rb = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            v = model(ro, 8'($urandom), rb);
            if ($urandom_range(0, 3) == 0) v.inj = $urandom_range(1, v.lat);
            do_op(v, $sformatf("rnd%0d_op%02h", i, ro));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
